hgcal_fc_stream_decoder: RTL and testbench
==========================================

Name: hgcal_fc_stream_decoder

Overview:
- ROC-side receiver for the fast-control link; the counterpart of the fc manager and simple serializer pair.
- Takes the 1-bit 320 Mb/s fast-control stream, finds the 8-bit word boundary by hunting for IDLE, and verifies lock.
- Regenerates a 40 MHz BX strobe and clock, and decodes each BX word into one-cycle command pulses for the readout and calibration logic.

Parameters:
- LOCK_COUNT, 4: consecutive valid words at the candidate phase needed to declare lock.
- UNLOCK_COUNT, 3: consecutive invalid words in LOCKED that drop lock.
- ORBIT_LEN, 3564: BXs per orbit; bx_count wraps at ORBIT_LEN-1.

Ports:
- clk320  input  1  320 MHz bit clock; the only clock.
- n_rstExt  input  1  asynchronous active-low reset.
- command_rx  input  1  serial fast-control bit, MSB of each word first.
- locked  output  1  word alignment established.
- bx_strobe  output  1  one clk320 cycle per decoded word.
- clk40_out  output  1  recovered 40 MHz clock.
- fc_word  output  8  last decoded word; valid with bx_strobe.
- l1a, orbit_sync, ocr, link_reset, daq_reset, calib_req  output  1 each  command pulses, one clk320 cycle, coincident with bx_strobe.
- decode_err  output  1  pulse when a LOCKED word is not in the code table.
- bx_count  output  12  BX within orbit (see Optional Feature).

Behaviour:
- Reset (n_rstExt=0, asynchronous):
  - all outputs 0; shift register 0; phase 0; good/bad counters 0; state SEARCH.
  - A mid-operation reset drops locked immediately, with no residual pulses.
- Shifting: each clk320 edge, sreg <= {sreg[6:0], command_rx}.
  - 3-bit phase counter increments modulo 8.
  - Phase 7 is the word boundary: sreg holds a complete word.
- State SEARCH:
  - Each cycle, compare sreg with FC_IDLE (8'hAC).
  - On a match, the phase counter is forced to 7 on that cycle, then proceeds to 0 next cycle.
  - On that match: state -> VERIFY, good_cnt <= 1.
- State VERIFY, at each boundary:
  - Word in code table: good_cnt+1. Reaching LOCK_COUNT -> LOCKED, bad_cnt <= 0.
  - Word not in code table: -> SEARCH, good_cnt <= 0.
- State LOCKED, at each boundary:
  - Valid word: bad_cnt <= 0.
  - Invalid word: bad_cnt+1 and decode_err pulses. Reaching UNLOCK_COUNT -> SEARCH; locked falls the cycle after the boundary.
- Outputs (registered, one clk320 cycle after the boundary):
  - locked = (state==LOCKED).
  - bx_strobe, fc_word and command pulses are asserted only in LOCKED; nothing is emitted in SEARCH/VERIFY.
- Code table (in package):
  - IDLE 8'hAC: no pulse.
  - L1A 8'h99, ORBIT_SYNC 8'hB4, OCR 8'hD2, LINK_RESET 8'hA5, DAQ_RESET 8'hC3, CALIB_REQ 8'h96: one pulse each.
  - LINK_DAQ_RESET 8'hE1: link_reset and daq_reset together.
  - Any other value is invalid.
- clk40_out = (phase >= 4), registered. It is free-running even when unlocked, and phase-aligned once VERIFY starts.
- Boundary conditions:
  - An IDLE match found in a non-boundary phase while in LOCKED is ignored; no realignment without unlock.
  - A word that decodes valid on the same boundary that bad_cnt would hit UNLOCK_COUNT clears bad_cnt; valid wins.

Optional Feature:
- Macro FC_BX_COUNTER_EN.
- With the macro defined:
  - bx_count increments on each bx_strobe and wraps ORBIT_LEN-1 -> 0.
  - orbit_sync or ocr forces it to 0 on the same strobe.
  - An orbit_sync arriving when bx_count != ORBIT_LEN-1 (after the first one) pulses decode_err.
  - The counter resets to 0 on unlock.
- Without the macro: bx_count is tied to 12'h000 and no orbit check is made.

Decomposition:
- Package hgcal_fc_pkg holds:
  - FC_* 8-bit code constants, shared with the encoder side;
  - the state enum (SEARCH, VERIFY, LOCKED);
  - the is_valid_code function.
- One natural sub-module, hgcal_fc_word_align: shift register, phase counter, and the SEARCH/VERIFY/LOCKED FSM, emitting word and boundary.
- The top level holds the decode and bx_count logic.

Test Plan:
1. Reset, then continuous IDLE at an arbitrary bit offset 3 -> locked=1 after 4 words plus 1 cycle; bx_strobe every 8 cycles; no command pulses.
2. Locked, send 8'h99 then 8'hE1 -> l1a pulse on the first strobe; link_reset and daq_reset on the second; fc_word matches each word.
3. Locked, inject 2 words of 8'h00 then IDLE -> 2 decode_err pulses and locked stays 1. With 3 bad words, locked falls and strobes stop.
4. Shift the stream by 1 bit mid-run -> unlock after 3 words, then relock at the new phase within 4 more words.
5. FC_BX_COUNTER_EN: orbit_sync, then 3563 IDLEs, then orbit_sync -> bx_count runs 0..3563 then back to 0; no decode_err. Send orbit_sync at BX 100 -> decode_err pulses.
6. Assert n_rstExt low during LOCKED mid-word -> all outputs 0 asynchronously; after release, reacquire per scenario 1.

Source files
------------

// File: rtl/hgcal_fc_pkg.sv
// Shared fast-control definitions: 8-bit command codes (common with the encoder side),
// alignment FSM states and the code-table helpers used by the ROC-side decoder.
package hgcal_fc_pkg;

    localparam logic [7:0] FC_IDLE           = 8'hAC;
    localparam logic [7:0] FC_L1A            = 8'h99;
    localparam logic [7:0] FC_ORBIT_SYNC     = 8'hB4;
    localparam logic [7:0] FC_OCR            = 8'hD2;
    localparam logic [7:0] FC_LINK_RESET     = 8'hA5;
    localparam logic [7:0] FC_DAQ_RESET      = 8'hC3;
    localparam logic [7:0] FC_CALIB_REQ      = 8'h96;
    localparam logic [7:0] FC_LINK_DAQ_RESET = 8'hE1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } fc_state_e;

    typedef struct packed {
        logic l1a;
        logic orbit_sync;
        logic ocr;
        logic link_reset;
        logic daq_reset;
        logic calib_req;
    } fc_cmd_t;

    function automatic logic is_valid_code(input logic [7:0] w);
        case (w)
            FC_IDLE, FC_L1A, FC_ORBIT_SYNC, FC_OCR, FC_LINK_RESET,
            FC_DAQ_RESET, FC_CALIB_REQ, FC_LINK_DAQ_RESET: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic fc_cmd_t decode_cmd(input logic [7:0] w);
        fc_cmd_t c;
        c = '0;
        case (w)
            FC_L1A:            c.l1a        = 1'b1;
            FC_ORBIT_SYNC:     c.orbit_sync = 1'b1;
            FC_OCR:            c.ocr        = 1'b1;
            FC_LINK_RESET:     c.link_reset = 1'b1;
            FC_DAQ_RESET:      c.daq_reset  = 1'b1;
            FC_CALIB_REQ:      c.calib_req  = 1'b1;
            FC_LINK_DAQ_RESET: begin
                c.link_reset = 1'b1;
                c.daq_reset  = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hgcal_fc_word_align.sv
// Word aligner: shifts the serial stream in, hunts for IDLE to set the word phase,
// then verifies and holds lock with good/bad word counters.
module hgcal_fc_word_align
    import hgcal_fc_pkg::*;
#(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3
) (
    input  logic       clk320,
    input  logic       n_rstExt,
    input  logic       command_rx,
    output logic [7:0] word_o,
    output logic       word_stb_o,
    output logic       phase_hi_o,
    output logic       locked_o
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [GW-1:0] LOCK_CNT   = GW'(LOCK_COUNT);
    localparam logic [BW-1:0] UNLOCK_CNT = BW'(UNLOCK_COUNT);

    logic [7:0]    sreg_q, sreg_d;
    logic [2:0]    phase_q, phase_d;
    fc_state_e     state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic [BW-1:0] bad_q, bad_d;
    logic          boundary;
    logic          valid;

    assign boundary = (phase_q == 3'd7);
    assign valid    = is_valid_code(sreg_q);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        sreg_d  = {sreg_q[6:0], command_rx};
        phase_d = phase_q + 3'd1;
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        case (state_q)
            SEARCH: begin
                // An IDLE match makes this cycle the boundary, so the next word starts at phase 0.
                if (sreg_q == FC_IDLE) begin
                    phase_d = 3'd0;
                    state_d = VERIFY;
                    good_d  = GW'(1);
                end
            end
            VERIFY: begin
                if (boundary) begin
                    if (valid) begin
                        good_d = good_q + GW'(1);
                        if (good_d == LOCK_CNT) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end else begin
                        state_d = SEARCH;
                        good_d  = '0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    if (valid) begin
                        bad_d = '0;
                    end else begin
                        bad_d = bad_q + BW'(1);
                        if (bad_d == UNLOCK_CNT) begin
                            state_d = SEARCH;
                            good_d  = '0;
                        end
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk320 or negedge n_rstExt) begin
        if (!n_rstExt) begin
            sreg_q  <= '0;
            phase_q <= '0;
            state_q <= SEARCH;
            good_q  <= '0;
            bad_q   <= '0;
        end else begin
            sreg_q  <= sreg_d;
            phase_q <= phase_d;
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
        end
    end

    assign word_o     = sreg_q;
    assign word_stb_o = (state_q == LOCKED) && boundary;
    assign phase_hi_o = phase_q[2];
    assign locked_o   = (state_q == LOCKED);

endmodule

// File: rtl/hgcal_fc_stream_decoder.sv
// ROC-side fast-control receiver: aligns the 320 Mb/s stream and turns each locked word
// into BX strobe, recovered clk40 and one-cycle command pulses. Macro FC_BX_COUNTER_EN adds bx_count.
module hgcal_fc_stream_decoder
    import hgcal_fc_pkg::*;
#(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3
`ifdef FC_BX_COUNTER_EN
    , parameter int ORBIT_LEN  = 3564
`endif
) (
    input  logic        clk320,
    input  logic        n_rstExt,
    input  logic        command_rx,
    output logic        locked,
    output logic        bx_strobe,
    output logic        clk40_out,
    output logic [7:0]  fc_word,
    output logic        l1a,
    output logic        orbit_sync,
    output logic        ocr,
    output logic        link_reset,
    output logic        daq_reset,
    output logic        calib_req,
    output logic        decode_err,
    output logic [11:0] bx_count
);

    logic [7:0] word;
    logic       word_stb;
    logic       phase_hi;
    logic       locked_int;

    hgcal_fc_word_align #(
        .LOCK_COUNT  (LOCK_COUNT),
        .UNLOCK_COUNT(UNLOCK_COUNT)
    ) u_align (
        .clk320    (clk320),
        .n_rstExt  (n_rstExt),
        .command_rx(command_rx),
        .word_o    (word),
        .word_stb_o(word_stb),
        .phase_hi_o(phase_hi),
        .locked_o  (locked_int)
    );

    logic       strobe_q, err_q, err_d, clk40_q;
    logic [7:0] fc_word_q, fc_word_d;
    fc_cmd_t    cmd_q, cmd_d;

`ifdef FC_BX_COUNTER_EN
    localparam logic [11:0] BX_LAST = 12'(ORBIT_LEN - 1);
    logic [11:0] bx_q, bx_d;
    logic        seen_orbit_q, seen_orbit_d;
`endif

    always_comb begin
        cmd_d     = '0;
        err_d     = 1'b0;
        fc_word_d = fc_word_q;
        if (word_stb) begin
            cmd_d     = decode_cmd(word);
            err_d     = !is_valid_code(word);
            fc_word_d = word;
        end
`ifdef FC_BX_COUNTER_EN
        bx_d         = bx_q;
        seen_orbit_d = seen_orbit_q;
        if (!locked_int) begin
            bx_d         = '0;
            seen_orbit_d = 1'b0;
        end else if (word_stb) begin
            // Only orbits after the first are checked against the expected orbit length.
            if (cmd_d.orbit_sync) begin
                if (seen_orbit_q && (bx_q != BX_LAST)) err_d = 1'b1;
                seen_orbit_d = 1'b1;
            end
            if (cmd_d.orbit_sync || cmd_d.ocr) bx_d = '0;
            else if (bx_q == BX_LAST)          bx_d = '0;
            else                               bx_d = bx_q + 12'd1;
        end
`endif
    end

    always_ff @(posedge clk320 or negedge n_rstExt) begin
        if (!n_rstExt) begin
            strobe_q  <= 1'b0;
            fc_word_q <= '0;
            cmd_q     <= '0;
            err_q     <= 1'b0;
            clk40_q   <= 1'b0;
        end else begin
            strobe_q  <= word_stb;
            fc_word_q <= fc_word_d;
            cmd_q     <= cmd_d;
            err_q     <= err_d;
            clk40_q   <= phase_hi;
        end
    end

`ifdef FC_BX_COUNTER_EN
    always_ff @(posedge clk320 or negedge n_rstExt) begin
        if (!n_rstExt) begin
            bx_q         <= '0;
            seen_orbit_q <= 1'b0;
        end else begin
            bx_q         <= bx_d;
            seen_orbit_q <= seen_orbit_d;
        end
    end
    assign bx_count = bx_q;
`else
    assign bx_count = 12'h000;
`endif

    assign locked     = locked_int;
    assign bx_strobe  = strobe_q;
    assign clk40_out  = clk40_q;
    assign fc_word    = fc_word_q;
    assign l1a        = cmd_q.l1a;
    assign orbit_sync = cmd_q.orbit_sync;
    assign ocr        = cmd_q.ocr;
    assign link_reset = cmd_q.link_reset;
    assign daq_reset  = cmd_q.daq_reset;
    assign calib_req  = cmd_q.calib_req;
    assign decode_err = err_q;

endmodule

// File: tb/tb_hgcal_fc_stream_decoder.sv
// Directed bench for hgcal_fc_stream_decoder: lock acquisition, command decode, error/unlock
// handling, bit slip realignment, optional BX counter and asynchronous reset.
module tb_hgcal_fc_stream_decoder;

    logic        clk320;
    logic        n_rstExt;
    logic        command_rx;
    logic        locked, bx_strobe, clk40_out;
    logic [7:0]  fc_word;
    logic        l1a, orbit_sync, ocr, link_reset, daq_reset, calib_req;
    logic        decode_err;
    logic [11:0] bx_count;

    hgcal_fc_stream_decoder dut (
        .clk320    (clk320),
        .n_rstExt  (n_rstExt),
        .command_rx(command_rx),
        .locked    (locked),
        .bx_strobe (bx_strobe),
        .clk40_out (clk40_out),
        .fc_word   (fc_word),
        .l1a       (l1a),
        .orbit_sync(orbit_sync),
        .ocr       (ocr),
        .link_reset(link_reset),
        .daq_reset (daq_reset),
        .calib_req (calib_req),
        .decode_err(decode_err),
        .bx_count  (bx_count)
    );

    initial clk320 = 1'b0;
    always #5 clk320 = ~clk320;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         lock_rise = -1;
    logic       prev_locked = 1'b0;

    // Per-word window observations; a word's decode shows up in the following window.
    int         w_strobes, w_idx, w_errs;
    logic [7:0] w_word;
    logic [5:0] w_cmd;
    logic [7:0] w_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        command_rx = b;
        @(posedge clk320);
        #1;
        cyc++;
        if (locked && !prev_locked) lock_rise = cyc;
        prev_locked = locked;
    endtask

    task automatic send_word(input logic [7:0] w);
        w_strobes = 0;
        w_idx     = -1;
        w_errs    = 0;
        w_cmd     = '0;
        w_clk     = '0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
            if (bx_strobe) begin
                w_strobes++;
                w_idx  = 7 - i;
                w_word = fc_word;
            end
            w_cmd |= {l1a, orbit_sync, ocr, link_reset, daq_reset, calib_req};
            if (decode_err) w_errs++;
            w_clk[7-i] = clk40_out;
        end
    endtask

    function automatic logic [29:0] all_outs();
        return {locked, bx_strobe, clk40_out, fc_word, l1a, orbit_sync, ocr,
                link_reset, daq_reset, calib_req, decode_err, bx_count};
    endfunction

    logic [7:0] codes   [8];
    logic [5:0] exp_cmd [8];
    int         t0;
    int         seq_bad;
    int         err_tot;

    initial begin
        codes   = '{8'h99, 8'hE1, 8'hB4, 8'hD2, 8'hA5, 8'hC3, 8'h96, 8'hAC};
        exp_cmd = '{6'b100000, 6'b000110, 6'b010000, 6'b001000,
                    6'b000100, 6'b000010, 6'b000001, 6'b000000};

        // Reset state
        n_rstExt   = 1'b1;
        command_rx = 1'b0;
        #1 n_rstExt = 1'b0;
        #2;
        check("reset_async_outs", 32'(all_outs()), 32'h0);
        repeat (2) @(posedge clk320);
        #1;
        check("reset_held_outs", 32'(all_outs()), 32'h0);
        n_rstExt = 1'b1;
        prev_locked = 1'b0;

        // 1: IDLE stream at bit offset 3
        repeat (3) send_bit(1'b0);
        lock_rise = -1;
        send_word(8'hAC);
        t0 = cyc;
        repeat (3) send_word(8'hAC);
        check("s1_not_locked_after_4", 32'(locked), 32'h0);
        send_word(8'hAC);
        check("s1_locked", 32'(locked), 32'h1);
        check("s1_lock_latency", 32'(lock_rise - t0), 32'd25);
        send_word(8'hAC);
        check("s1_strobe_count", 32'(w_strobes), 32'd1);
        check("s1_strobe_pos", 32'(w_idx), 32'd0);
        check("s1_fc_word", 32'(w_word), 32'hAC);
        check("s1_no_cmd", 32'(w_cmd), 32'h0);
        check("s1_clk40_pattern", 32'(w_clk), 32'hE1);
        send_word(8'hAC);
        check("s1_strobe_count2", 32'(w_strobes), 32'd1);
        check("s1_no_err", 32'(w_errs), 32'd0);

        // 2: command decode table
        for (int i = 0; i < 8; i++) begin
            send_word(codes[i]);
            if (i > 0) begin
                check($sformatf("s2_word_%0h", codes[i-1]), 32'(w_word), 32'(codes[i-1]));
                check($sformatf("s2_cmd_%0h", codes[i-1]), 32'(w_cmd), 32'(exp_cmd[i-1]));
                check($sformatf("s2_err_%0h", codes[i-1]), 32'(w_errs), 32'd0);
            end
        end

        // 3: bad words, valid word clears the bad count, then three bad words unlock
        send_word(8'h00);
        send_word(8'h00);
        check("s3_err1", 32'(w_errs), 32'd1);
        send_word(8'hAC);
        check("s3_err2", 32'(w_errs), 32'd1);
        check("s3_still_locked", 32'(locked), 32'h1);
        send_word(8'hAC);
        check("s3_idle_no_err", 32'(w_errs), 32'd0);
        send_word(8'h00);
        send_word(8'h00);
        check("s3_valid_cleared_bad", 32'(locked), 32'h1);
        send_word(8'h00);
        check("s3_locked_before_fall", 32'(locked), 32'h1);
        send_word(8'h00);
        check("s3_err3", 32'(w_errs), 32'd1);
        check("s3_unlocked", 32'(locked), 32'h0);
        send_word(8'h00);
        check("s3_strobes_stop", 32'(w_strobes), 32'd0);
        check("s3_no_cmd_unlocked", 32'(w_cmd), 32'h0);
        lock_rise = -1;
        send_word(8'hAC);
        t0 = cyc;
        repeat (4) send_word(8'hAC);
        check("s3_relocked", 32'(locked), 32'h1);
        check("s3_relock_latency", 32'(lock_rise - t0), 32'd25);

`ifdef FC_BX_COUNTER_EN
        // 5: BX counter across a full orbit, then an early orbit_sync
        send_word(8'hB4);
        seq_bad = 0;
        err_tot = 0;
        for (int j = 1; j <= 3563; j++) begin
            send_word(8'hAC);
            if (bx_count !== 12'(j - 1)) seq_bad++;
            err_tot += w_errs;
        end
        check("s5_bx_sequence", 32'(seq_bad), 32'd0);
        check("s5_no_err_orbit", 32'(err_tot), 32'd0);
        send_word(8'hB4);
        check("s5_bx_last", 32'(bx_count), 32'd3563);
        send_word(8'hAC);
        check("s5_bx_wrap", 32'(bx_count), 32'd0);
        check("s5_orbit_ok_err", 32'(w_errs), 32'd0);
        check("s5_orbit_pulse", 32'(w_cmd), 32'b010000);
        repeat (99) send_word(8'hAC);
        check("s5_bx_99", 32'(bx_count), 32'd99);
        send_word(8'hB4);
        send_word(8'hAC);
        check("s5_early_orbit_err", 32'(w_errs), 32'd1);
        check("s5_early_orbit_bx", 32'(bx_count), 32'd0);
`else
        check("s5_bx_tied", 32'(bx_count), 32'h0);
`endif

        // 4: one-bit slip while locked
        send_bit(1'b0);
        send_word(8'hAC);
        check("s4_err_w1", 32'(w_errs), 32'd1);
        check("s4_strobe_pos_w1", 32'(w_idx), 32'd7);
        send_word(8'hAC);
        check("s4_locked_w2", 32'(locked), 32'h1);
        check("s4_err_w2", 32'(w_errs), 32'd1);
        send_word(8'hAC);
        check("s4_unlocked_w3", 32'(locked), 32'h0);
        t0 = cyc;
        lock_rise = -1;
        repeat (4) send_word(8'hAC);
        check("s4_relocked", 32'(locked), 32'h1);
        check("s4_relock_latency", 32'(lock_rise - t0), 32'd25);

        // 6: asynchronous reset mid-word while locked
        send_word(8'hAC);
        send_bit(1'b1);
        check("s6_strobe_before_rst", 32'(bx_strobe), 32'h1);
        #2 n_rstExt = 1'b0;
        #1;
        check("s6_async_outs", 32'(all_outs()), 32'h0);
        @(posedge clk320);
        #1;
        check("s6_held_outs", 32'(all_outs()), 32'h0);
        n_rstExt = 1'b1;
        prev_locked = 1'b0;
        repeat (3) send_bit(1'b0);
        lock_rise = -1;
        send_word(8'hAC);
        t0 = cyc;
        repeat (4) send_word(8'hAC);
        check("s6_relocked", 32'(locked), 32'h1);
        check("s6_relock_latency", 32'(lock_rise - t0), 32'd25);
        send_word(8'hAC);
        check("s6_strobe_pos", 32'(w_idx), 32'd0);
        check("s6_fc_word", 32'(w_word), 32'hAC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
